// File: rtl/jk_bank_driver.sv
// Command-driven driver for a bank of falling-edge JK flip-flops with active-low preset/clear.
// A shadow copy of the bank state is checked against the bank readback; any disagreement is sticky.
module jk_bank_driver #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_mask_i,
  input  logic [CNT_W-1:0] cmd_count_i,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o,
  output logic [WIDTH-1:0] preset_o,
  output logic [WIDTH-1:0] clear_o,
  output logic             jk_clk_o,
  input  logic [WIDTH-1:0] q_fb_i,
  output logic [WIDTH-1:0] q_model_o,
  output logic             mismatch_o,
  output logic             busy_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_HI    = 3'd2;
  localparam logic [2:0] ST_LO    = 3'd3;
  localparam logic [2:0] ST_ASYNC = 3'd4;

  localparam logic [2:0] OP_RESET  = 3'd1;
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_TOGGLE = 3'd3;
  localparam logic [2:0] OP_PRESET = 3'd4;
  localparam logic [2:0] OP_CLEAR  = 3'd5;

  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZEROS    = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic [WIDTH-1:0] preset_q, preset_d, clear_q, clear_d;
  logic             jk_clk_q, jk_clk_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] q_model_q, q_model_d;
  logic             mismatch_q, mismatch_d;

  logic             accept_s;
  logic             async_op_s;
  logic [CNT_W-1:0] count_s;

  // Bank J/K levels for a JK op: RESET 01, SET 10, TOGGLE 11, anything else 00 (returns {j, k}).
  function automatic logic [2*WIDTH-1:0] jk_drive(input logic [2:0] op, input logic [WIDTH-1:0] mask);
    logic [2*WIDTH-1:0] jk;
    case (op)
      OP_RESET:  jk = {ZEROS, mask};
      OP_SET:    jk = {mask, ZEROS};
      OP_TOGGLE: jk = {mask, mask};
      default:   jk = {ZEROS, ZEROS};
    endcase
    return jk;
  endfunction

  // Shadow state after one falling jk_clk edge.
  function automatic logic [WIDTH-1:0] jk_next(input logic [2:0] op, input logic [WIDTH-1:0] mask,
                                               input logic [WIDTH-1:0] q);
    logic [WIDTH-1:0] nq;
    case (op)
      OP_RESET:  nq = q & ~mask;
      OP_SET:    nq = q | mask;
      OP_TOGGLE: nq = q ^ mask;
      default:   nq = q;
    endcase
    return nq;
  endfunction

  assign accept_s   = cmd_valid_i & ready_q;
  assign async_op_s = (cmd_op_i == OP_PRESET) || (cmd_op_i == OP_CLEAR);
  assign count_s    = (cmd_count_i == CNT_ZERO) ? CNT_ONE : cmd_count_i;

  // Next state and next registered outputs; outputs are computed for the state being entered.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    j_d        = ZEROS;
    k_d        = ZEROS;
    preset_d   = ONES;
    clear_d    = ONES;
    jk_clk_d   = 1'b0;
    ready_d    = 1'b0;
    q_model_d  = q_model_q;
    mismatch_d = mismatch_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          op_d   = cmd_op_i;
          mask_d = cmd_mask_i;
          cnt_d  = count_s;
          if (async_op_s) begin
            state_d = ST_ASYNC;
            if (cmd_op_i == OP_PRESET) begin
              preset_d  = ~cmd_mask_i;
              q_model_d = q_model_q | cmd_mask_i;
            end else begin
              clear_d   = ~cmd_mask_i;
              q_model_d = q_model_q & ~cmd_mask_i;
            end
          end else begin
            state_d    = ST_SETUP;
            {j_d, k_d} = jk_drive(cmd_op_i, cmd_mask_i);
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_SETUP: begin
        state_d    = ST_HI;
        jk_clk_d   = 1'b1;
        {j_d, k_d} = jk_drive(op_q, mask_q);
      end
      ST_HI: begin
        state_d    = ST_LO;
        {j_d, k_d} = jk_drive(op_q, mask_q);
        q_model_d  = jk_next(op_q, mask_q, q_model_q);
      end
      ST_LO: begin
        if (q_fb_i != q_model_q) begin
          mismatch_d = 1'b1;
        end else begin
          mismatch_d = mismatch_q;
        end
        if (cnt_q != CNT_ONE) begin
          cnt_d      = cnt_q - CNT_ONE;
          state_d    = ST_HI;
          jk_clk_d   = 1'b1;
          {j_d, k_d} = jk_drive(op_q, mask_q);
        end else begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      ST_ASYNC: begin
        if (cnt_q != CNT_ONE) begin
          cnt_d = cnt_q - CNT_ONE;
          if (op_q == OP_PRESET) begin
            preset_d = ~mask_q;
          end else begin
            clear_d = ~mask_q;
          end
        end else begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          if (q_fb_i != q_model_q) begin
            mismatch_d = 1'b1;
          end else begin
            mismatch_d = mismatch_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
    busy_d = ~ready_d;
  end

  // State and output registers; reset holds the bank cleared.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      op_q       <= 3'd0;
      mask_q     <= ZEROS;
      cnt_q      <= CNT_ZERO;
      j_q        <= ZEROS;
      k_q        <= ZEROS;
      preset_q   <= ONES;
      clear_q    <= ZEROS;
      jk_clk_q   <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b1;
      q_model_q  <= ZEROS;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      j_q        <= j_d;
      k_q        <= k_d;
      preset_q   <= preset_d;
      clear_q    <= clear_d;
      jk_clk_q   <= jk_clk_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      q_model_q  <= q_model_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign j_o         = j_q;
  assign k_o         = k_q;
  assign preset_o    = preset_q;
  assign clear_o     = clear_q;
  assign jk_clk_o    = jk_clk_q;
  assign q_model_o   = q_model_q;
  assign mismatch_o  = mismatch_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: a behavioural JK bank answers on q_fb, and a command-level
// reference model predicts busy time, pulse count, shadow state trace and flags.
module tb_jk_bank_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [3:0] cmd_mask = 4'd0;
  logic [7:0] cmd_count = 8'd0;
  logic [3:0] j, k, preset, clear, q_fb, q_model;
  logic       jk_clk, mismatch, busy;

  logic [3:0] bank_q = 4'd0;
  logic       prev_jk = 1'b0;
  logic       stuck0 = 1'b0;
  logic [3:0] exp_q = 4'd0;

  int n_cmp = 0;
  int n_bad = 0;

  int         obs_busy, obs_pulses, obs_low;
  logic [3:0] obs_j, obs_k, obs_pre, obs_clr;
  logic [3:0] obs_trace[$];
  bit         obs_to;

  jk_bank_driver #(.WIDTH(4), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_mask_i(cmd_mask), .cmd_count_i(cmd_count),
    .j_o(j), .k_o(k), .preset_o(preset), .clear_o(clear), .jk_clk_o(jk_clk),
    .q_fb_i(q_fb), .q_model_o(q_model), .mismatch_o(mismatch), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Behavioural bank: JK capture on falling jk_clk, then active-low preset/clear override.
  always @(jk_clk or preset or clear) begin
    if (prev_jk === 1'b1 && jk_clk === 1'b0) bank_q = (j & ~bank_q) | (~k & bank_q);
    prev_jk = jk_clk;
    bank_q  = (bank_q | ~preset) & clear;
  end

  assign q_fb = stuck0 ? (bank_q & 4'b1110) : bank_q;

  function automatic logic [3:0] ref_apply(input logic [2:0] op, input logic [3:0] m, input logic [3:0] q);
    case (op)
      3'd1, 3'd5: return q & ~m;
      3'd2, 3'd4: return q | m;
      3'd3:       return q ^ m;
      default:    return q;
    endcase
  endfunction

  // Issues one command from a negedge and records what the DUT did until it is idle again.
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] m, input logic [7:0] c);
    int   g;
    logic prev_hi;
    obs_busy = 0; obs_pulses = 0; obs_low = 0; obs_to = 1'b0;
    obs_j = 4'd0; obs_k = 4'd0; obs_pre = 4'hF; obs_clr = 4'hF;
    obs_trace.delete();
    g = 0;
    while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) obs_to = 1'b1;
    cmd_valid = 1'b1; cmd_op = op; cmd_mask = m; cmd_count = c;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    prev_hi = 1'b0; g = 0;
    while (busy && g < 2000) begin
      obs_busy++;
      if (jk_clk) begin obs_pulses++; obs_j = j; obs_k = k; end
      else if (prev_hi) obs_trace.push_back(q_model);
      if (preset != 4'hF || clear != 4'hF) begin obs_low++; obs_pre = preset; obs_clr = clear; end
      prev_hi = jk_clk;
      @(negedge clk); g++;
    end
    if (g >= 2000) obs_to = 1'b1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_q = 4'd0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (clear !== 4'b0000) begin n_bad++; $display("FAIL reset_clear: got %b want 0000", clear); end
      n_cmp++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got ready=%b busy=%b want 0/1", cmd_ready, busy); end
      n_cmp++; if ({j, k, jk_clk, preset} !== {4'd0, 4'd0, 1'b0, 4'hF}) begin n_bad++; $display("FAIL reset_drive: got j=%b k=%b clk=%b pre=%b", j, k, jk_clk, preset); end
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (clear !== 4'b1111) begin n_bad++; $display("FAIL idle_clear: got %b want 1111", clear); end
    n_cmp++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL idle_ready: got ready=%b busy=%b want 1/0", cmd_ready, busy); end
    n_cmp++; if (q_model !== 4'd0 || mismatch !== 1'b0) begin n_bad++; $display("FAIL idle_model: got q=%b mm=%b want 0000/0", q_model, mismatch); end
    exp_q = 4'd0;
  endtask

  task automatic test_set();
    run_cmd(3'd2, 4'b0101, 8'd1);
    n_cmp++; if (obs_to) begin n_bad++; $display("FAIL set_timeout: got timeout want done"); end
    n_cmp++; if (obs_j !== 4'b0101 || obs_k !== 4'b0000) begin n_bad++; $display("FAIL set_jk: got j=%b k=%b want 0101/0000", obs_j, obs_k); end
    n_cmp++; if (obs_pulses !== 1) begin n_bad++; $display("FAIL set_pulses: got %0d want 1", obs_pulses); end
    n_cmp++; if (obs_busy !== 3) begin n_bad++; $display("FAIL set_busy: got %0d want 3", obs_busy); end
    n_cmp++; if (q_model !== 4'b0101 || mismatch !== 1'b0) begin n_bad++; $display("FAIL set_model: got q=%b mm=%b want 0101/0", q_model, mismatch); end
    exp_q = 4'b0101;
  endtask

  task automatic test_toggle();
    do_reset(2);
    run_cmd(3'd3, 4'b1111, 8'd3);
    n_cmp++; if (obs_busy !== 7 || obs_pulses !== 3) begin n_bad++; $display("FAIL tog_timing: got busy=%0d pulses=%0d want 7/3", obs_busy, obs_pulses); end
    n_cmp++; if (obs_trace.size() !== 3) begin n_bad++; $display("FAIL tog_trace_len: got %0d want 3", obs_trace.size()); end
    else begin
      n_cmp++; if (obs_trace[0] !== 4'hF || obs_trace[1] !== 4'h0 || obs_trace[2] !== 4'hF) begin
        n_bad++; $display("FAIL tog_trace: got %b/%b/%b want 1111/0000/1111", obs_trace[0], obs_trace[1], obs_trace[2]); end
    end
    n_cmp++; if (q_model !== 4'hF || mismatch !== 1'b0) begin n_bad++; $display("FAIL tog_model: got q=%b mm=%b want 1111/0", q_model, mismatch); end
    exp_q = 4'hF;
  endtask

  task automatic test_preset();
    run_cmd(3'd5, 4'b1111, 8'd1);
    exp_q = 4'd0;
    run_cmd(3'd4, 4'b1000, 8'd2);
    n_cmp++; if (obs_pre !== 4'b0111 || obs_low !== 2) begin n_bad++; $display("FAIL pre_pulse: got pre=%b cycles=%0d want 0111/2", obs_pre, obs_low); end
    n_cmp++; if (obs_busy !== 2 || obs_pulses !== 0) begin n_bad++; $display("FAIL pre_timing: got busy=%0d pulses=%0d want 2/0", obs_busy, obs_pulses); end
    n_cmp++; if (q_model !== 4'b1000 || q_fb !== 4'b1000) begin n_bad++; $display("FAIL pre_model: got q=%b fb=%b want 1000", q_model, q_fb); end
    exp_q = 4'b1000;
  endtask

  // cmd_valid held continuously; the op is swapped while the first command is still busy.
  task automatic test_back_to_back();
    logic       bs[6];
    logic [3:0] qs[6];
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_mask = 4'b0011; cmd_count = 8'd1;
    @(posedge clk); #1;
    cmd_op = 3'd5; cmd_mask = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bs[i] = busy; qs[i] = q_model;
      if (i == 4) cmd_valid = 1'b0;
    end
    n_cmp++; if ({bs[0], bs[1], bs[2], bs[3], bs[4], bs[5]} !== 6'b111010) begin
      n_bad++; $display("FAIL b2b_busy: got %b%b%b%b%b%b want 111010", bs[0], bs[1], bs[2], bs[3], bs[4], bs[5]); end
    n_cmp++; if (qs[2] !== (exp_q | 4'b0011)) begin n_bad++; $display("FAIL b2b_first: got %b want %b", qs[2], exp_q | 4'b0011); end
    n_cmp++; if (qs[4] !== 4'd0 || mismatch !== 1'b0) begin n_bad++; $display("FAIL b2b_second: got q=%b mm=%b want 0000/0", qs[4], mismatch); end
    exp_q = 4'd0;
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [3:0] m;
    logic [7:0] c;
    int         n, wb, wl;
    bit         asy;
    logic [3:0] want[$];
    for (int it = 0; it < 26; it++) begin
      op = 3'($urandom_range(0, 7)); m = 4'($urandom_range(0, 15)); c = 8'($urandom_range(0, 5));
      if (it == 24) begin op = 3'd2; m = 4'd0; c = 8'd2; end
      if (it == 25) begin op = 3'd3; c = 8'd255; end
      n = (c == 8'd0) ? 1 : int'(c);
      asy = (op == 3'd4) || (op == 3'd5);
      want.delete();
      if (asy) exp_q = ref_apply(op, m, exp_q);
      else for (int p = 0; p < n; p++) begin exp_q = ref_apply(op, m, exp_q); want.push_back(exp_q); end
      wb = asy ? n : 1 + 2 * n;
      wl = (asy && m != 4'd0) ? n : 0;
      run_cmd(op, m, c);
      n_cmp++; if (obs_to) begin n_bad++; $display("FAIL rnd%0d_timeout: got timeout want done", it); end
      n_cmp++; if (obs_busy !== wb) begin n_bad++; $display("FAIL rnd%0d_busy: op=%0d got %0d want %0d", it, op, obs_busy, wb); end
      n_cmp++; if (obs_pulses !== (asy ? 0 : n)) begin n_bad++; $display("FAIL rnd%0d_pulses: got %0d want %0d", it, obs_pulses, asy ? 0 : n); end
      n_cmp++; if (obs_low !== wl) begin n_bad++; $display("FAIL rnd%0d_async_cycles: got %0d want %0d", it, obs_low, wl); end
      n_cmp++; if (q_model !== exp_q || q_fb !== exp_q) begin n_bad++; $display("FAIL rnd%0d_model: op=%0d m=%b got q=%b fb=%b want %b", it, op, m, q_model, q_fb, exp_q); end
      n_cmp++; if (mismatch !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_mismatch: got 1 want 0", it); end
      if (asy && m != 4'd0) begin
        n_cmp++; if ({obs_pre, obs_clr} !== ((op == 3'd4) ? {~m, 4'hF} : {4'hF, ~m})) begin
          n_bad++; $display("FAIL rnd%0d_async_drive: got pre=%b clr=%b mask=%b", it, obs_pre, obs_clr, m); end
      end
      if (!asy) begin
        n_cmp++; if (obs_j !== (((op == 3'd2) || (op == 3'd3)) ? m : 4'd0) || obs_k !== (((op == 3'd1) || (op == 3'd3)) ? m : 4'd0)) begin
          n_bad++; $display("FAIL rnd%0d_jk: op=%0d m=%b got j=%b k=%b", it, op, m, obs_j, obs_k); end
        n_cmp++; if (obs_trace.size() !== want.size()) begin n_bad++; $display("FAIL rnd%0d_trace_len: got %0d want %0d", it, obs_trace.size(), want.size()); end
        else for (int p = 0; p < want.size(); p++) begin
          n_cmp++; if (obs_trace[p] !== want[p]) begin n_bad++; $display("FAIL rnd%0d_trace%0d: got %b want %b", it, p, obs_trace[p], want[p]); end
        end
      end
    end
  endtask

  task automatic test_fault();
    stuck0 = 1'b1;
    run_cmd(3'd2, 4'b0001, 8'd1);
    n_cmp++; if (mismatch !== 1'b1) begin n_bad++; $display("FAIL fault_detect: got %b want 1", mismatch); end
    n_cmp++; if (q_model[0] !== 1'b1) begin n_bad++; $display("FAIL fault_model: got %b want bit0 set", q_model); end
    stuck0 = 1'b0;
    run_cmd(3'd5, 4'b0001, 8'd1);
    n_cmp++; if (mismatch !== 1'b1) begin n_bad++; $display("FAIL fault_sticky: got %b want 1", mismatch); end
    n_cmp++; if (q_model[0] !== 1'b0 || q_fb[0] !== 1'b0) begin n_bad++; $display("FAIL fault_clear: got q=%b fb=%b want bit0 clear", q_model, q_fb); end
    do_reset(2);
    n_cmp++; if (mismatch !== 1'b0) begin n_bad++; $display("FAIL fault_rst: got %b want 0", mismatch); end
  endtask

  task automatic test_rst_mid();
    int g;
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_mask = 4'b1111; cmd_count = 8'd5;
    @(posedge clk);
    @(negedge clk);
    g = 0;
    while (!jk_clk && g < 10) begin @(negedge clk); g++; end
    n_cmp++; if (g >= 10) begin n_bad++; $display("FAIL mid_hi: got no jk_clk pulse want HI"); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({jk_clk, j, k} !== 9'd0) begin n_bad++; $display("FAIL mid_drive: got clk=%b j=%b k=%b want 0", jk_clk, j, k); end
    n_cmp++; if (clear !== 4'd0 || q_model !== 4'd0 || q_fb !== 4'd0) begin n_bad++; $display("FAIL mid_clear: got clr=%b q=%b fb=%b want 0", clear, q_model, q_fb); end
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL mid_hold: got ready=%b busy=%b want 0/1", cmd_ready, busy); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_release: got ready=%b busy=%b want 1/0", cmd_ready, busy); end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_accept: got busy=%b want 1", busy); end
    g = 0;
    while (busy && g < 100) begin @(negedge clk); g++; end
    n_cmp++; if (g >= 100) begin n_bad++; $display("FAIL mid_done: got timeout want idle"); end
    n_cmp++; if (q_model !== 4'hF || q_fb !== 4'hF || mismatch !== 1'b0) begin
      n_bad++; $display("FAIL mid_final: got q=%b fb=%b mm=%b want 1111/1111/0", q_model, q_fb, mismatch); end
  endtask

  initial begin
    test_reset();
    test_set();
    test_toggle();
    test_preset();
    test_back_to_back();
    test_random();
    test_fault();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jk_bank_driver.md
# jk_bank_driver

Command-driven upstream stage for a bank of `WIDTH` JK flip-flops with active-low preset/clear and falling-edge capture. It accepts commands over a valid/ready handshake and generates registered `j`, `k`, `preset`, `clear` and a strobe clock `jk_clk` for the bank. It keeps a shadow model of the bank state, compares it against the bank's `q` readback after every update, and raises a sticky flag on any mismatch.

## Interface
- `WIDTH`, 4, number of flip-flops in the driven bank
- `CNT_W`, 8, width of the command repeat count
- `clk` input 1: system clock; all logic on rising edge
- `rst` input 1: synchronous, active-high reset
- `cmd_valid` input 1: command present
- `cmd_ready` output 1: block idle and able to accept a command
- `cmd_op` input 3: 0 HOLD, 1 RESET, 2 SET, 3 TOGGLE, 4 PRESET, 5 CLEAR, 6/7 treated as HOLD
- `cmd_mask` input WIDTH: bits affected by the command
- `cmd_count` input CNT_W: number of jk_clk pulses (JK ops) or assert cycles (PRESET/CLEAR); 0 treated as 1
- `j`, `k` output WIDTH: JK inputs to the bank
- `preset`, `clear` output WIDTH: active-low asynchronous preset/clear to the bank
- `jk_clk` output 1: bank clock; the bank captures on its falling edge
- `q_fb` input WIDTH: bank `q` readback
- `q_model` output WIDTH: shadow bank state
- `mismatch` output 1: sticky; set when `q_fb != q_model` at a check point
- `busy` output 1: equals `~cmd_ready`

## Operation
- All outputs are registered. `jk_clk` is therefore glitch-free.
- States:
  - IDLE
  - SETUP
  - HI
  - LO
  - ASYNC
- **IDLE**
  - `cmd_ready=1`, `j=k=0`, `preset=clear=all ones`, `jk_clk=0`.
  - On `cmd_valid & cmd_ready`, latch op, mask and count (0 becomes 1).
  - JK ops (0-3, 6, 7) go to SETUP. Ops 4 and 5 go to ASYNC.
- **SETUP** (1 cycle)
  - Drive `j`/`k` per op on masked bits: HOLD 00, RESET 01, SET 10, TOGGLE 11.
  - Unmasked bits are driven 00. `jk_clk=0`.
  - Next state: HI.
- **HI** (1 cycle)
  - `jk_clk=1`, `j`/`k` held.
  - Next state: LO.
  - On the HI->LO edge, `q_model` is updated on masked bits: HOLD keeps, RESET clears, SET sets, TOGGLE inverts.
- **LO** (1 cycle)
  - `jk_clk=0`. The bank updates at the start of this cycle.
  - At the end of LO, compare `q_fb` with `q_model` on all bits; any difference sets `mismatch`.
  - Decrement the remaining count. If it is nonzero, go to HI; otherwise go to IDLE.
- **ASYNC**
  - Drive `preset` (op 4) or `clear` (op 5) low on masked bits for `count` cycles. `jk_clk=0`, `j=k=0`.
  - `q_model` masked bits are forced to 1 (op 4) or 0 (op 5) on entry.
  - Compare at the end of the last ASYNC cycle, then go to IDLE.
- `mismatch` is cleared only by `rst`.
- `cmd_valid` while busy is ignored; the command is not consumed.
- `mask=0`: full timing is executed, `j`/`k`/`preset`/`clear` stay inactive, `q_model` is unchanged, and checks still occur.

## Timing
- Reset values:
  - state IDLE
  - `cmd_ready=0` while `rst` is high
  - `j=k=0`, `preset=all ones`, `clear=all zeros` (clears the bank during reset), `jk_clk=0`
  - `q_model=0`, `mismatch=0`, `busy=1`
- The first edge after `rst` falls enters IDLE: `clear=all ones`, `cmd_ready=1`.
- JK command with count N: accept edge, then 1 SETUP + 2N cycles busy. `cmd_ready=1` on the cycle after the final LO.
- PRESET/CLEAR with count N: N cycles busy.
- Back-to-back throughput: at least one IDLE cycle between commands.
- `rst` mid-command aborts within one edge, and all outputs take their reset values. A partially pulsed bank is resynchronised by the reset-time clear.
- The count register wraps nowhere: the maximum count is 2^CNT_W-1 pulses, and 0 maps to 1.

## Test plan
- Reset then idle: `rst` high 3 cycles -> `clear=0000` and `cmd_ready=0` during reset; one cycle after release `clear=1111`, `q_model=0000`, `cmd_ready=1`.
- SET mask 0101 count 1 with `q_fb` tracking a JK model -> `j=0101`, `k=0000`, one `jk_clk` pulse, `q_model=0101`, `mismatch=0`, busy exactly 3 cycles.
- TOGGLE mask 1111 count 3 from 0000 -> three `jk_clk` pulses, `q_model` sequence 1111/0000/1111, busy 7 cycles.
- PRESET mask 1000 count 2 -> `preset=0111` for 2 cycles, `q_model=1xxx` bit set, `jk_clk` stays 0.
- Fault: `q_fb` bit 0 stuck 0, then SET mask 0001 -> `mismatch=1` at the end of LO; it stays 1 after a later successful CLEAR and clears only on `rst`.
- `rst` asserted during HI of a count-5 TOGGLE -> next edge `jk_clk=0`, `j=k=0`, `clear=all zeros`, `q_model=0`; `cmd_valid` held throughout is not accepted until after release.
